fifo_axis_rd_ctrl: RTL and testbench
====================================

Name: fifo_axis_rd_ctrl

Overview:
Read-side controller for the team's asynchronous FIFO in the PCIe path.
- Drains FIFO words and frames them as an AXI-stream master with tlast every pkt_len beats.
- Flushes a short packet (early tlast) when data stalls mid-packet longer than a programmable timeout.
- Sits in the FIFO read clock domain, between the FIFO read port and the downstream PCIe TX packetizer.

Parameters:
DATA_WIDTH, 16, FIFO read word width and m_axis_tdata width.
LEN_WIDTH, 16, width of pkt_len and the beat counter.
TO_WIDTH, 16, width of timeout and the idle timer.

Ports:
clk  input  1  controller clock; same clock as the FIFO read port.
rstn  input  1  reset, asynchronous, active-low.
enable  input  1  permits new FIFO reads.
pkt_len  input  LEN_WIDTH  beats per full packet; 0 is treated as 1.
timeout  input  TO_WIDTH  stall cycles before a short-packet flush; 0 disables flushing.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read enable.
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
m_axis_tdata  output  DATA_WIDTH  stream data.
m_axis_tvalid  output  1  stream valid.
m_axis_tready  input  1  stream ready.
m_axis_tlast  output  1  end of packet.
busy  output  1  high when occ != 0 or inflight = 1.
pkt_cnt  output  32  completed packets; wraps.
short_pkt_cnt  output  32  packets closed by timeout; wraps.

Behaviour:
- Reset values: all outputs 0; buffer and occupancy (occ) 0; inflight 0; beat_cnt 0; timer 0; flush flag 0.
- Reset is asynchronous and clears everything immediately. Buffered words are discarded; the FIFO is not rewound.
- Read issue: fifo_rd_en = enable & !fifo_empty & (occ + inflight < 2).
  - This is combinational; inflight is fifo_rd_en registered.
  - Capture fifo_rd_data into the 2-entry buffer only when inflight = 1. The FIFO drives zero on non-read cycles, so nothing is sampled otherwise.
- Buffer: 2-entry FIFO, head = oldest word.
  - A beat is accepted when tvalid & tready; acceptance pops the head.
  - Capture and pop may occur in the same cycle; occ is updated correctly.
  - occ never exceeds 2.
- Packet length: pkt_len is latched into len_q when the first beat of a packet is accepted, and also whenever beat_cnt = 0. Mid-packet changes do not affect the current packet.
- Beat counter: increments on each accepted beat and returns to 0 on an accepted tlast beat.
- tvalid = head valid & (occ = 2 | inflight | beat_cnt = len_q-1 | flush).
  - A lone head with no successor pending is held back, because its tlast is not yet known.
- tlast = (beat_cnt = len_q-1) | (flush & occ = 1 & !inflight).
- AXI rule: once tvalid is high, tvalid, tdata and tlast stay stable until tready.
  - tlast is evaluated and committed at the cycle tvalid rises.
  - A word arriving after a committed flush tlast does not change it; that word starts the next packet.
- Idle timer: counts while all of these hold: occ = 1, !inflight, beat_cnt != len_q-1, flush = 0.
  - Clears whenever that condition drops.
  - When timeout != 0 and the timer reaches timeout-1, flush sets.
  - Result: tvalid rises exactly timeout cycles after the hold condition first holds.
- flush clears on the accepted beat. If that beat had tlast via flush (not via the length match), short_pkt_cnt increments.
- pkt_cnt increments on every accepted tlast beat.
- Hold states: HOLD is occ = 1 with tvalid low; FLUSH is flush = 1.
- enable low: no new reads are issued. The inflight word is still captured. Buffered words drain under the same rules, including timeout.
- pkt_len = 1: every beat carries tlast; no hold ever occurs.

Test Plan:
1. pkt_len=4, timeout=0, FIFO holds 1..8, tready=1 → beats 1..8, tlast on 4 and 8, pkt_cnt=2, short_pkt_cnt=0, busy=0 at end.
2. Same data, tready random 50% → output sequence 1..8 with no loss or duplication; tdata/tlast stable during stalls; fifo_rd_en never high when occ + inflight = 2.
3. pkt_len=8, timeout=10, FIFO holds 3 words, tready=1 → words 1 and 2 out with tlast=0; word 3 tvalid rises 10 cycles after the hold starts with tlast=1; short_pkt_cnt=1, pkt_cnt=1.
4. As 3, but tready=0 during the flush, then write word 4 → word 3 keeps tlast=1; word 4 is held as a new packet with beat_cnt=0.
5. timeout=0, pkt_len=8, 3 words → words 1 and 2 out; word 3 held indefinitely with tvalid=0 and busy=1.
6. Assert rstn low mid-packet with occ=2 → all outputs 0 the same cycle; after release, new FIFO data starts with beat_cnt=0.

Source files
------------

// File: rtl/fifo_axis_rd_ctrl.sv
// Read-side controller for the async FIFO: drains words into a 2-entry skid buffer
// and frames them as an AXI-stream master, flushing short packets after a data stall.
module fifo_axis_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [TO_WIDTH-1:0]   timeout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           short_pkt_cnt
);

    logic                  inflight_p0;
    logic [DATA_WIDTH-1:0] head_p1, tail_p1;
    logic [1:0]            occ_p1;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, len_q;
    logic [TO_WIDTH-1:0]   timer_q;
    logic                  flush_q;
    logic                  held_q, last_cmt_q, short_cmt_q;

    logic                  head_vld, last_match, last_flush, vld;
    logic                  last_sel, short_sel, accept, hold_cond;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [1:0]            level;

    assign len_eff    = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    assign level      = occ_p1 + {1'b0, inflight_p0};
    assign fifo_rd_en = rstn & enable & ~fifo_empty & (level < 2'd2);

    assign head_vld   = (occ_p1 != 2'd0);
    assign last_match = (beat_cnt_q == len_q - LEN_WIDTH'(1));
    assign last_flush = flush_q & (occ_p1 == 2'd1) & ~inflight_p0;
    assign hold_cond  = (occ_p1 == 2'd1) & ~inflight_p0 & ~last_match & ~flush_q;

    // A lone head waits for a successor (or length match / flush) so its tlast is known.
    assign vld        = head_vld & (held_q | (occ_p1 == 2'd2) | inflight_p0 | last_match | flush_q);
    assign last_sel   = held_q ? last_cmt_q  : (last_match | last_flush);
    assign short_sel  = held_q ? short_cmt_q : (last_flush & ~last_match);
    assign accept     = vld & m_axis_tready;

    assign m_axis_tvalid = vld;
    assign m_axis_tdata  = head_p1;
    assign m_axis_tlast  = vld & last_sel;
    assign busy          = head_vld | inflight_p0;

    // p0 -> p1: read data lands one cycle after the read; capture and pop may coincide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_p0 <= 1'b0;
            head_p1     <= '0;
            tail_p1     <= '0;
            occ_p1      <= 2'd0;
        end else begin
            inflight_p0 <= fifo_rd_en;
            case ({inflight_p0, accept})
                2'b10: begin
                    if (occ_p1 == 2'd0) head_p1 <= fifo_rd_data;
                    else                tail_p1 <= fifo_rd_data;
                    occ_p1 <= occ_p1 + 2'd1;
                end
                2'b01: begin
                    head_p1 <= tail_p1;
                    occ_p1  <= occ_p1 - 2'd1;
                end
                2'b11: begin
                    if (occ_p1 == 2'd1) begin
                        head_p1 <= fifo_rd_data;
                    end else begin
                        head_p1 <= tail_p1;
                        tail_p1 <= fifo_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // p1 -> stream: framing state; tlast is frozen once a beat is offered and stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q    <= '0;
            len_q         <= '0;
            timer_q       <= '0;
            flush_q       <= 1'b0;
            held_q        <= 1'b0;
            last_cmt_q    <= 1'b0;
            short_cmt_q   <= 1'b0;
            pkt_cnt       <= '0;
            short_pkt_cnt <= '0;
        end else begin
            held_q      <= vld & ~m_axis_tready;
            last_cmt_q  <= last_sel;
            short_cmt_q <= short_sel;
            if ((beat_cnt_q == '0) && (!vld || m_axis_tready))
                len_q <= len_eff;
            timer_q <= hold_cond ? timer_q + TO_WIDTH'(1) : '0;
            if (accept) begin
                flush_q <= 1'b0;
                if (last_sel) begin
                    beat_cnt_q <= '0;
                    pkt_cnt    <= pkt_cnt + 32'd1;
                    if (short_sel)
                        short_pkt_cnt <= short_pkt_cnt + 32'd1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                end
            end else if (hold_cond && (timeout != '0) && (timer_q == timeout - TO_WIDTH'(1))) begin
                flush_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_rd_ctrl.sv
// Directed bench for fifo_axis_rd_ctrl: behavioural FIFO on the read side, beat monitor on the stream side.
module tb_fifo_axis_rd_ctrl;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] pkt_len = 16'd4;
    logic [TW-1:0] timeout = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic [31:0]   pkt_cnt;
    logic [31:0]   short_pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_axis_rd_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TO_WIDTH(TW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .timeout      (timeout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt),
        .short_pkt_cnt(short_pkt_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO read port: data one cycle after rd_en, zero otherwise
    logic [DW-1:0] fifo_mem [64];
    int wptr = 0;
    int rptr = 0;
    assign fifo_empty = (rptr == wptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rptr % 64];
            rptr         <= rptr + 1;
        end else begin
            fifo_rd_data <= '0;
        end
    end

    task automatic push(input int d);
        fifo_mem[wptr % 64] = DW'(d);
        wptr++;
    endtask

    // Stream monitor: records accepted beats, checks stall stability and the read guard
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            issued = 0;
    int            accepted = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                check("stall_tvalid", 32'(m_axis_tvalid), 1);
                check("stall_tdata", 32'(m_axis_tdata), 32'(prev_d));
                check("stall_tlast", 32'(m_axis_tlast), 32'(prev_l));
            end
            if (fifo_rd_en)
                check("rd_guard", 32'((issued - accepted) < 2), 1);
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                accepted <= accepted + 1;
            end
            if (fifo_rd_en)
                issued <= issued + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_d     <= m_axis_tdata;
            prev_l     <= m_axis_tlast;
        end else begin
            prev_stall <= 1'b0;
            issued     <= 0;
            accepted   <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        got_d.delete();
        got_l.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic run_until(input int n, input int max_cyc, input bit rnd);
        int c = 0;
        while (got_d.size() < n && c < max_cyc) begin
            tick();
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            c++;
        end
        check("beats_done", 32'(got_d.size() >= n), 1);
    endtask

    task automatic check_seq8(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_data"}, 32'(got_d[i]), i + 1);
            check({tag, "_last"}, 32'(got_l[i]), ((i == 3) || (i == 7)) ? 1 : 0);
        end
        check({tag, "_count"}, got_d.size(), 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;

        // 1: reset state, then pkt_len=4 with words 1..8 and tready held high
        pkt_len = 16'd4;
        timeout = '0;
        for (int i = 1; i <= 8; i++) push(i);
        enable = 1'b1;
        @(negedge clk);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_short_cnt", short_pkt_cnt, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        m_axis_tready = 1'b1;
        run_until(8, 200, 1'b0);
        repeat (4) tick();
        check_seq8("t1");
        check("t1_pkt_cnt", pkt_cnt, 2);
        check("t1_short_cnt", short_pkt_cnt, 0);
        check("t1_busy", 32'(busy), 0);

        // 2: same data, random backpressure
        do_reset();
        pkt_len = 16'd4;
        for (int i = 1; i <= 8; i++) push(i);
        enable = 1'b1;
        run_until(8, 600, 1'b1);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check_seq8("t2");
        check("t2_pkt_cnt", pkt_cnt, 2);
        check("t2_busy", 32'(busy), 0);

        // 3: pkt_len=8, timeout=10, three words -> flush after exactly 10 hold cycles
        do_reset();
        pkt_len = 16'd8;
        timeout = 16'd10;
        for (int i = 1; i <= 3; i++) push(i);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        run_until(2, 100, 1'b0);
        @(negedge clk);
        check("t3_hold_tvalid", 32'(m_axis_tvalid), 0);
        check("t3_hold_busy", 32'(busy), 1);
        cnt = 0;
        while (!m_axis_tvalid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_flush_delay", cnt, 10);
        check("t3_flush_tdata", 32'(m_axis_tdata), 3);
        check("t3_flush_tlast", 32'(m_axis_tlast), 1);
        repeat (3) tick();
        check("t3_w1_last", 32'(got_l[0]), 0);
        check("t3_w2_last", 32'(got_l[1]), 0);
        check("t3_w3_data", 32'(got_d[2]), 3);
        check("t3_w3_last", 32'(got_l[2]), 1);
        check("t3_pkt_cnt", pkt_cnt, 1);
        check("t3_short_cnt", short_pkt_cnt, 1);
        check("t3_busy", 32'(busy), 0);

        // 4: flush beat stalled, a fourth word arrives behind it
        do_reset();
        pkt_len = 16'd8;
        timeout = 16'd10;
        for (int i = 1; i <= 3; i++) push(i);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        run_until(2, 100, 1'b0);
        m_axis_tready = 1'b0;
        cnt = 0;
        while (!m_axis_tvalid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_flush_tvalid", 32'(m_axis_tvalid), 1);
        check("t4_flush_tlast", 32'(m_axis_tlast), 1);
        tick();
        push(4);
        repeat (3) tick();
        @(negedge clk);
        check("t4_keep_tvalid", 32'(m_axis_tvalid), 1);
        check("t4_keep_tdata", 32'(m_axis_tdata), 3);
        check("t4_keep_tlast", 32'(m_axis_tlast), 1);
        tick();
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("t4_w4_held", 32'(m_axis_tvalid), 0);
        check("t4_w4_busy", 32'(busy), 1);
        check("t4_short_cnt", short_pkt_cnt, 1);
        check("t4_pkt_cnt", pkt_cnt, 1);
        check("t4_w3_last", 32'(got_l[2]), 1);
        tick();
        pkt_len = 16'd1;
        @(posedge clk);
        @(negedge clk);
        check("t4_w4_new_tvalid", 32'(m_axis_tvalid), 1);
        check("t4_w4_new_tdata", 32'(m_axis_tdata), 4);
        check("t4_w4_new_tlast", 32'(m_axis_tlast), 1);
        tick();
        m_axis_tready = 1'b1;
        run_until(4, 50, 1'b0);
        repeat (2) tick();
        check("t4_pkt_cnt_end", pkt_cnt, 2);
        check("t4_short_cnt_end", short_pkt_cnt, 1);

        // 5: no timeout -> the third word is held indefinitely
        do_reset();
        pkt_len = 16'd8;
        timeout = '0;
        for (int i = 1; i <= 3; i++) push(i);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        run_until(2, 100, 1'b0);
        repeat (40) tick();
        @(negedge clk);
        check("t5_tvalid", 32'(m_axis_tvalid), 0);
        check("t5_busy", 32'(busy), 1);
        check("t5_beats", got_d.size(), 2);
        check("t5_pkt_cnt", pkt_cnt, 0);

        // 6: asynchronous reset with two buffered words
        do_reset();
        pkt_len = 16'd2;
        timeout = '0;
        push(1);
        push(2);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        run_until(2, 100, 1'b0);
        check("t6_pkt1_last", 32'(got_l[1]), 1);
        m_axis_tready = 1'b0;
        push(3);
        push(4);
        push(5);
        repeat (8) tick();
        @(negedge clk);
        check("t6_pre_tvalid", 32'(m_axis_tvalid), 1);
        check("t6_pre_tdata", 32'(m_axis_tdata), 3);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("t6_rst_tlast", 32'(m_axis_tlast), 0);
        check("t6_rst_tdata", 32'(m_axis_tdata), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_rd_en", 32'(fifo_rd_en), 0);
        check("t6_rst_pkt_cnt", pkt_cnt, 0);
        base = got_d.size();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        m_axis_tready = 1'b1;
        repeat (6) tick();
        check("t6_w5_held", 32'(m_axis_tvalid), 0);
        push(6);
        run_until(base + 2, 100, 1'b0);
        repeat (2) tick();
        check("t6_w5_data", 32'(got_d[base]), 5);
        check("t6_w5_last", 32'(got_l[base]), 0);
        check("t6_w6_data", 32'(got_d[base + 1]), 6);
        check("t6_w6_last", 32'(got_l[base + 1]), 1);
        check("t6_pkt_cnt", pkt_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
